// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the external memory port arbiter.
// Request/response bundles for the IBus/DBus side, AXI channel bundles for the
// SoC master side, and the read/write channel FSM state encodings.
package mem_bus_pkg;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // len is AXI-style: number of beats minus one.
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [7:0]  len;
    } rd_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic        rlast;
        logic [31:0] rdata;
    } rd_resp_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } wr_req_t;

    typedef struct packed {
        logic gnt;
        logic wready;
        logic done;
    } wr_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ar_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_aw_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
    } axi_r_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef enum logic [1:0] {
        RIdle,
        RAddr,
        RData
    } rd_state_e;

    typedef enum logic [1:0] {
        WIdle,
        WAddr,
        WData,
        WResp
    } wr_state_e;

    typedef enum logic {
        OwnerIcache,
        OwnerDcache
    } rd_owner_e;

    // Line index of an address: drop the in-line byte offset.
    function automatic logic [31:0] line_of(input logic [31:0] addr,
                                            input int unsigned offset_w);
        return addr >> offset_w;
    endfunction

endpackage

// File: rtl/mem_rd_arbiter.sv
// Read-channel arbiter: decides which cache read path owns the next AR burst.
// DCache has priority; after STARVE_LIMIT consecutive DCache grants with the
// ICache waiting, the ICache gets the next grant. A DCache read that targets
// the line of the in-flight write is not eligible.
// Ports:
//   clk, reset      clock, async active-low reset
//   arb_en_i        read channel is idle and may accept a new burst
//   ibus_req_i      ICache read request
//   dbus_req_i      DCache read request
//   dbus_addr_i     DCache read address (for the write-line compare)
//   wline_valid_i   a write burst is in flight
//   wline_i         line index of the in-flight write
//   grant_o         a requester wins this cycle
//   winner_o        which requester wins (valid with grant_o)
module mem_rd_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter int unsigned LINE_OFFSET_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arb_en_i,
    input  logic        ibus_req_i,
    input  logic        dbus_req_i,
    input  logic [31:0] dbus_addr_i,
    input  logic        wline_valid_i,
    input  logic [31:0] wline_i,
    output logic        grant_o,
    output rd_owner_e   winner_o
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            dbus_elig;
    logic            ibus_elig;
    logic            icache_turn;

    assign dbus_elig   = dbus_req_i &&
                         !(wline_valid_i && (line_of(dbus_addr_i, LINE_OFFSET_W) == wline_i));
    assign ibus_elig   = ibus_req_i;
    assign icache_turn = ibus_elig && (starve_cnt_q == Limit);

    always_comb begin
        grant_o  = 1'b0;
        winner_o = OwnerIcache;
        if (arb_en_i) begin
            if (dbus_elig && !icache_turn) begin
                grant_o  = 1'b1;
                winner_o = OwnerDcache;
            end else if (ibus_elig) begin
                grant_o  = 1'b1;
                winner_o = OwnerIcache;
            end
        end
    end

    // Counts DCache grants that overtook a waiting ICache request.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!ibus_req_i) begin
            starve_cnt_d = '0;
        end else if (grant_o && (winner_o == OwnerIcache)) begin
            starve_cnt_d = '0;
        end else if (grant_o && (winner_o == OwnerDcache) && (starve_cnt_q != Limit)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single AXI master port between the ICache read path, the DCache
// read path and the DCache write path. Read and write channels are owned by
// independent FSMs that run concurrently; a DCache read to the line of the
// in-flight write is held off until that write completes.
// Ports:
//   clk, reset                 clock, async active-low reset
//   ibus_rd_i / ibus_rd_o      ICache read request / grant + read data
//   dbus_rd_i / dbus_rd_o      DCache read request / grant + read data
//   dbus_wr_i / dbus_wr_o      DCache write request + data / grant, wready, done
//   ar_o, arready_i            AXI read address channel
//   r_i, rready_o              AXI read data channel
//   aw_o, awready_i            AXI write address channel
//   w_o, wready_i              AXI write data channel
//   bvalid_i, bready_o         AXI write response channel
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter int unsigned LINE_OFFSET_W = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  rd_req_t  ibus_rd_i,
    output rd_resp_t ibus_rd_o,
    input  rd_req_t  dbus_rd_i,
    output rd_resp_t dbus_rd_o,
    input  wr_req_t  dbus_wr_i,
    output wr_resp_t dbus_wr_o,
    output axi_ar_t  ar_o,
    input  logic     arready_i,
    input  axi_r_t   r_i,
    output logic     rready_o,
    output axi_aw_t  aw_o,
    input  logic     awready_i,
    output axi_w_t   w_o,
    input  logic     wready_i,
    input  logic     bvalid_i,
    output logic     bready_o
);

    // Read channel state
    rd_state_e   rd_state_q, rd_state_d;
    rd_owner_e   rd_owner_q, rd_owner_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [7:0]  rd_len_q, rd_len_d;
    logic        ibus_gnt_q, ibus_gnt_d;
    logic        dbus_gnt_q, dbus_gnt_d;

    // Write channel state
    wr_state_e   wr_state_q, wr_state_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_len_q, wr_len_d;
    logic [7:0]  wr_beat_q, wr_beat_d;
    logic        wr_gnt_q, wr_gnt_d;
    logic        wr_done_q, wr_done_d;
    logic        wline_valid_q, wline_valid_d;
    logic [31:0] wline_q, wline_d;

    logic        arb_grant;
    rd_owner_e   arb_winner;

    // The bus-error response is reserved and not acted on.
    logic        unused_rresp;
    assign unused_rresp = ^r_i.resp;

    mem_rd_arbiter #(
        .STARVE_LIMIT  (STARVE_LIMIT),
        .LINE_OFFSET_W (LINE_OFFSET_W)
    ) u_rd_arb (
        .clk           (clk),
        .reset         (reset),
        .arb_en_i      (rd_state_q == RIdle),
        .ibus_req_i    (ibus_rd_i.req),
        .dbus_req_i    (dbus_rd_i.req),
        .dbus_addr_i   (dbus_rd_i.addr),
        .wline_valid_i (wline_valid_q),
        .wline_i       (wline_q),
        .grant_o       (arb_grant),
        .winner_o      (arb_winner)
    );

    // Read FSM next state
    always_comb begin
        rd_state_d = rd_state_q;
        rd_owner_d = rd_owner_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;
        ibus_gnt_d = 1'b0;
        dbus_gnt_d = 1'b0;
        unique case (rd_state_q)
            RIdle: begin
                if (arb_grant) begin
                    rd_owner_d = arb_winner;
                    if (arb_winner == OwnerDcache) begin
                        rd_addr_d  = dbus_rd_i.addr;
                        rd_len_d   = dbus_rd_i.len;
                        dbus_gnt_d = 1'b1;
                    end else begin
                        rd_addr_d  = ibus_rd_i.addr;
                        rd_len_d   = ibus_rd_i.len;
                        ibus_gnt_d = 1'b1;
                    end
                    rd_state_d = RAddr;
                end
            end
            RAddr: begin
                if (arready_i) begin
                    rd_state_d = RData;
                end
            end
            RData: begin
                if (r_i.valid && r_i.last) begin
                    rd_state_d = RIdle;
                end
            end
            default: rd_state_d = RIdle;
        endcase
    end

    // Read channel outputs; read data is steered to the owner in the same cycle.
    always_comb begin
        ar_o      = '0;
        rready_o  = 1'b0;
        ibus_rd_o = '0;
        dbus_rd_o = '0;
        ibus_rd_o.gnt = ibus_gnt_q;
        dbus_rd_o.gnt = dbus_gnt_q;
        if (rd_state_q == RAddr) begin
            ar_o.valid = 1'b1;
            ar_o.addr  = rd_addr_q;
            ar_o.len   = rd_len_q;
            ar_o.size  = AXI_SIZE_WORD;
            ar_o.burst = AXI_BURST_INCR;
        end
        if (rd_state_q == RData) begin
            rready_o = 1'b1;
            if (r_i.valid) begin
                if (rd_owner_q == OwnerDcache) begin
                    dbus_rd_o.rvalid = 1'b1;
                    dbus_rd_o.rdata  = r_i.data;
                    dbus_rd_o.rlast  = r_i.last;
                end else begin
                    ibus_rd_o.rvalid = 1'b1;
                    ibus_rd_o.rdata  = r_i.data;
                    ibus_rd_o.rlast  = r_i.last;
                end
            end
        end
    end

    // Write FSM next state
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_addr_d     = wr_addr_q;
        wr_len_d      = wr_len_q;
        wr_beat_d     = wr_beat_q;
        wr_gnt_d      = 1'b0;
        wr_done_d     = 1'b0;
        wline_valid_d = wline_valid_q;
        wline_d       = wline_q;
        unique case (wr_state_q)
            WIdle: begin
                if (dbus_wr_i.req) begin
                    wr_gnt_d      = 1'b1;
                    wr_addr_d     = dbus_wr_i.addr;
                    wr_len_d      = dbus_wr_i.len;
                    wr_beat_d     = '0;
                    wline_valid_d = 1'b1;
                    wline_d       = line_of(dbus_wr_i.addr, LINE_OFFSET_W);
                    wr_state_d    = WAddr;
                end
            end
            WAddr: begin
                if (awready_i) begin
                    wr_state_d = WData;
                end
            end
            WData: begin
                if (wready_i) begin
                    if (wr_beat_q == wr_len_q) begin
                        wr_state_d = WResp;
                    end else begin
                        wr_beat_d = wr_beat_q + 8'd1;
                    end
                end
            end
            WResp: begin
                if (bvalid_i) begin
                    wr_done_d     = 1'b1;
                    wline_valid_d = 1'b0;
                    wr_state_d    = WIdle;
                end
            end
            default: wr_state_d = WIdle;
        endcase
    end

    // Write channel outputs; write data is taken straight from the DCache.
    always_comb begin
        aw_o      = '0;
        w_o       = '0;
        bready_o  = 1'b0;
        dbus_wr_o = '0;
        dbus_wr_o.gnt  = wr_gnt_q;
        dbus_wr_o.done = wr_done_q;
        if (wr_state_q == WAddr) begin
            aw_o.valid = 1'b1;
            aw_o.addr  = wr_addr_q;
            aw_o.len   = wr_len_q;
            aw_o.size  = AXI_SIZE_WORD;
            aw_o.burst = AXI_BURST_INCR;
        end
        if (wr_state_q == WData) begin
            w_o.valid        = 1'b1;
            w_o.data         = dbus_wr_i.wdata;
            w_o.strb         = dbus_wr_i.wstrb;
            w_o.last         = (wr_beat_q == wr_len_q);
            dbus_wr_o.wready = wready_i;
        end
        if (wr_state_q == WResp) begin
            bready_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state_q    <= RIdle;
            rd_owner_q    <= OwnerIcache;
            rd_addr_q     <= '0;
            rd_len_q      <= '0;
            ibus_gnt_q    <= 1'b0;
            dbus_gnt_q    <= 1'b0;
            wr_state_q    <= WIdle;
            wr_addr_q     <= '0;
            wr_len_q      <= '0;
            wr_beat_q     <= '0;
            wr_gnt_q      <= 1'b0;
            wr_done_q     <= 1'b0;
            wline_valid_q <= 1'b0;
            wline_q       <= '0;
        end else begin
            rd_state_q    <= rd_state_d;
            rd_owner_q    <= rd_owner_d;
            rd_addr_q     <= rd_addr_d;
            rd_len_q      <= rd_len_d;
            ibus_gnt_q    <= ibus_gnt_d;
            dbus_gnt_q    <= dbus_gnt_d;
            wr_state_q    <= wr_state_d;
            wr_addr_q     <= wr_addr_d;
            wr_len_q      <= wr_len_d;
            wr_beat_q     <= wr_beat_d;
            wr_gnt_q      <= wr_gnt_d;
            wr_done_q     <= wr_done_d;
            wline_valid_q <= wline_valid_d;
            wline_q       <= wline_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs are driven just after the falling
// edge and outputs are checked 1 time unit later, away from the rising edge.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic     clk;
    logic     reset;
    rd_req_t  ibus_rd_i;
    rd_resp_t ibus_rd_o;
    rd_req_t  dbus_rd_i;
    rd_resp_t dbus_rd_o;
    wr_req_t  dbus_wr_i;
    wr_resp_t dbus_wr_o;
    axi_ar_t  ar_o;
    logic     arready_i;
    axi_r_t   r_i;
    logic     rready_o;
    axi_aw_t  aw_o;
    logic     awready_i;
    axi_w_t   w_o;
    logic     wready_i;
    logic     bvalid_i;
    logic     bready_o;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(
        .STARVE_LIMIT  (4),
        .LINE_OFFSET_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ibus_rd_i (ibus_rd_i),
        .ibus_rd_o (ibus_rd_o),
        .dbus_rd_i (dbus_rd_i),
        .dbus_rd_o (dbus_rd_o),
        .dbus_wr_i (dbus_wr_i),
        .dbus_wr_o (dbus_wr_o),
        .ar_o      (ar_o),
        .arready_i (arready_i),
        .r_i       (r_i),
        .rready_o  (rready_o),
        .aw_o      (aw_o),
        .awready_i (awready_i),
        .w_o       (w_o),
        .wready_i  (wready_i),
        .bvalid_i  (bvalid_i),
        .bready_o  (bready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] all_outs();
        return {ibus_rd_o, dbus_rd_o, dbus_wr_o, ar_o, rready_o, aw_o, w_o, bready_o};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got_q[$];
        bit exp_q[$];
        bit last_d;
        int beat;

        reset     = 1'b0;
        ibus_rd_i = '0;
        dbus_rd_i = '0;
        dbus_wr_i = '0;
        arready_i = 1'b0;
        r_i       = '0;
        awready_i = 1'b0;
        wready_i  = 1'b0;
        bvalid_i  = 1'b0;
        #1;
        chk("reset_outs", all_outs(), '0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("post_reset_outs", all_outs(), '0);

        // ICache-only 4-beat read, AR accepted on its second cycle
        ibus_rd_i = '{req: 1'b1, addr: 32'h1FC0_0000, len: 8'd3};
        #1;
        chk("t1_gnt_early", ibus_rd_o.gnt, 0);
        tick();
        ibus_rd_i.req = 1'b0;
        #1;
        chk("t1_gnt", ibus_rd_o.gnt, 1);
        chk("t1_dgnt", dbus_rd_o.gnt, 0);
        chk("t1_arvalid", ar_o.valid, 1);
        chk("t1_araddr", ar_o.addr, 32'h1FC0_0000);
        chk("t1_arlen", ar_o.len, 3);
        chk("t1_arsize", ar_o.size, 3'b010);
        chk("t1_arburst", ar_o.burst, 2'b01);
        tick();
        arready_i = 1'b1;
        #1;
        chk("t1_gnt_pulse", ibus_rd_o.gnt, 0);
        chk("t1_arvalid_hold", ar_o.valid, 1);
        tick();
        arready_i = 1'b0;
        #1;
        chk("t1_arvalid_off", ar_o.valid, 0);
        chk("t1_rready", rready_o, 1);
        for (int b = 0; b < 4; b++) begin
            r_i = '{valid: 1'b1, data: 32'hA5A5_0000 + b, last: (b == 3), resp: 2'b00};
            #1;
            chk("t1_rvalid", ibus_rd_o.rvalid, 1);
            chk("t1_rdata", ibus_rd_o.rdata, 32'hA5A5_0000 + b);
            chk("t1_rlast", ibus_rd_o.rlast, (b == 3));
            chk("t1_d_rvalid", dbus_rd_o.rvalid, 0);
            tick();
        end
        r_i = '0;
        #1;
        chk("t1_rready_off", rready_o, 0);

        // Both requesters held, zero-length bursts: starvation limit ordering
        exp_q = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        ibus_rd_i = '{req: 1'b1, addr: 32'h0000_1000, len: 8'd0};
        dbus_rd_i = '{req: 1'b1, addr: 32'h0000_2000, len: 8'd0};
        arready_i = 1'b1;
        r_i = '{valid: 1'b1, data: 32'hCAFE_0001, last: 1'b1, resp: 2'b10};
        last_d = 1'b0;
        for (int c = 0; c < 60 && got_q.size() < 10; c++) begin
            tick();
            #1;
            if (ibus_rd_o.gnt || dbus_rd_o.gnt) begin
                chk("t2_gnt_excl", ibus_rd_o.gnt & dbus_rd_o.gnt, 0);
                chk("t2_arlen", ar_o.len, 0);
                chk("t2_araddr", ar_o.addr, dbus_rd_o.gnt ? 32'h0000_2000 : 32'h0000_1000);
                last_d = dbus_rd_o.gnt;
                got_q.push_back(dbus_rd_o.gnt);
            end
            if (rready_o) begin
                chk("t2_owner_rlast", last_d ? dbus_rd_o.rlast : ibus_rd_o.rlast, 1);
                chk("t2_other_rvalid", last_d ? ibus_rd_o.rvalid : dbus_rd_o.rvalid, 0);
            end
        end
        chk("t2_ngrant", got_q.size(), 10);
        for (int i = 0; i < got_q.size(); i++) begin
            chk($sformatf("t2_order%0d", i), got_q[i], exp_q[i]);
        end
        ibus_rd_i.req = 1'b0;
        dbus_rd_i.req = 1'b0;
        tick();
        tick();
        tick();
        r_i = '0;
        arready_i = 1'b0;
        #1;
        chk("t2_idle", ar_o.valid | rready_o, 0);

        // Write 0x80001000 len 3; other-line read proceeds, same-line read waits
        dbus_wr_i = '{req: 1'b1, addr: 32'h8000_1000, len: 8'd3, wdata: 32'h0, wstrb: 4'hF};
        #1;
        chk("t3_wgnt_early", dbus_wr_o.gnt, 0);
        tick();
        dbus_wr_i.req = 1'b0;
        dbus_rd_i = '{req: 1'b1, addr: 32'h8000_2000, len: 8'd0};
        #1;
        chk("t3_wgnt", dbus_wr_o.gnt, 1);
        chk("t3_awvalid", aw_o.valid, 1);
        chk("t3_awaddr", aw_o.addr, 32'h8000_1000);
        chk("t3_awlen", aw_o.len, 3);
        tick();
        dbus_rd_i.req = 1'b0;
        arready_i = 1'b1;
        #1;
        chk("t3_other_gnt", dbus_rd_o.gnt, 1);
        chk("t3_other_araddr", ar_o.addr, 32'h8000_2000);
        chk("t3_aw_hold", aw_o.valid, 1);
        chk("t3_wgnt_pulse", dbus_wr_o.gnt, 0);
        tick();
        arready_i = 1'b0;
        r_i = '{valid: 1'b1, data: 32'h0000_0055, last: 1'b1, resp: 2'b00};
        #1;
        chk("t3_other_rdata", dbus_rd_o.rdata, 32'h0000_0055);
        chk("t3_other_rlast", dbus_rd_o.rlast, 1);
        chk("t3_other_i_rvalid", ibus_rd_o.rvalid, 0);
        tick();
        r_i = '0;
        dbus_rd_i = '{req: 1'b1, addr: 32'h8000_100C, len: 8'd0};
        awready_i = 1'b1;
        tick();
        awready_i = 1'b0;
        #1;
        chk("t3_blocked", dbus_rd_o.gnt, 0);
        chk("t3_aw_off", aw_o.valid, 0);
        beat = 0;
        for (int k = 0; k < 16; k++) begin
            wready_i = (k % 2 == 0);
            dbus_wr_i.wdata = 32'hD000_0000 + beat;
            #1;
            chk("t3_wvalid", w_o.valid, 1);
            chk("t3_wdata", w_o.data, 32'hD000_0000 + beat);
            chk("t3_wstrb", w_o.strb, 4'hF);
            chk("t3_wlast", w_o.last, (beat == 3));
            chk("t3_wready_o", dbus_wr_o.wready, wready_i);
            chk("t3_blocked_w", dbus_rd_o.gnt, 0);
            if (wready_i) beat++;
            if (beat == 4) break;
            tick();
        end
        chk("t3_beats", beat, 4);
        tick();
        wready_i = 1'b0;
        #1;
        chk("t3_wvalid_off", w_o.valid, 0);
        chk("t3_bready", bready_o, 1);
        chk("t3_done_early", dbus_wr_o.done, 0);
        tick();
        bvalid_i = 1'b1;
        #1;
        chk("t3_bready_hold", bready_o, 1);
        chk("t3_done_same", dbus_wr_o.done, 0);
        tick();
        bvalid_i = 1'b0;
        #1;
        chk("t3_done", dbus_wr_o.done, 1);
        chk("t3_blocked_done", dbus_rd_o.gnt, 0);
        chk("t3_bready_off", bready_o, 0);
        tick();
        #1;
        chk("t3_done_pulse", dbus_wr_o.done, 0);
        chk("t3_release_gnt", dbus_rd_o.gnt, 1);
        chk("t3_release_araddr", ar_o.addr, 32'h8000_100C);
        dbus_rd_i.req = 1'b0;
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        r_i = '{valid: 1'b1, data: 32'h0000_0066, last: 1'b1, resp: 2'b00};
        #1;
        chk("t3_release_rdata", dbus_rd_o.rdata, 32'h0000_0066);
        tick();
        r_i = '0;

        // Asynchronous reset with both channels in their data phases
        ibus_rd_i = '{req: 1'b1, addr: 32'h0000_0100, len: 8'd1};
        dbus_wr_i = '{req: 1'b1, addr: 32'h0000_3000, len: 8'd1, wdata: 32'h1234, wstrb: 4'hF};
        arready_i = 1'b1;
        awready_i = 1'b1;
        tick();
        ibus_rd_i.req = 1'b0;
        dbus_wr_i.req = 1'b0;
        #1;
        chk("t5_igmt", ibus_rd_o.gnt, 1);
        chk("t5_wgnt", dbus_wr_o.gnt, 1);
        tick();
        arready_i = 1'b0;
        awready_i = 1'b0;
        r_i = '{valid: 1'b1, data: 32'h0000_0077, last: 1'b0, resp: 2'b00};
        #1;
        chk("t5_rvalid_pre", ibus_rd_o.rvalid, 1);
        chk("t5_wvalid_pre", w_o.valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_outs", all_outs(), '0);
        r_i = '0;
        dbus_wr_i = '0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("t5_released_outs", all_outs(), '0);
        ibus_rd_i = '{req: 1'b1, addr: 32'h1FC0_0040, len: 8'd0};
        tick();
        ibus_rd_i.req = 1'b0;
        #1;
        chk("t5_fresh_gnt", ibus_rd_o.gnt, 1);
        chk("t5_fresh_araddr", ar_o.addr, 32'h1FC0_0040);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        r_i = '{valid: 1'b1, data: 32'h0000_0088, last: 1'b1, resp: 2'b00};
        #1;
        chk("t5_fresh_rdata", ibus_rd_o.rdata, 32'h0000_0088);
        chk("t5_fresh_rlast", ibus_rd_o.rlast, 1);
        tick();
        r_i = '0;
        #1;
        chk("t5_fresh_idle", rready_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
